// File: rtl/fixed_point_seq_unit_pkg.sv
// Shared op codes and FSM state encoding for the fixed-point sequential unit.
package fixed_point_seq_unit_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_SUB  = 2'd1,
        FPU_MUL  = 2'd2,
        FPU_SQRT = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        FPU_ST_IDLE = 2'd0,
        FPU_ST_EXEC = 2'd1,
        FPU_ST_DONE = 2'd2
    } fpu_state_e;

endpackage

// File: rtl/fixed_point_seq_unit_fpu_slice_multiplier.sv
// Combinational WIDTH x MUL_SLICE unsigned partial-product generator.
module fpu_slice_multiplier
    import fixed_point_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_SLICE = 8
) (
    input  logic [WIDTH-1:0]           a_i,
    input  logic [MUL_SLICE-1:0]       b_i,
    output logic [WIDTH+MUL_SLICE-1:0] p_o
);

    always_comb begin
        p_o = {{MUL_SLICE{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    end

endmodule

// File: rtl/fixed_point_seq_unit.sv
// Sequential Q-format ADD/SUB/MUL/SQRT unit with start/busy/done handshake.
// Define FPU_SATURATION_EN to clamp overflowing ADD/SUB/MUL results instead of wrapping.
module fixed_point_seq_unit
    import fixed_point_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FBITS     = 10,
    parameter int unsigned MUL_SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             invalid
);

    localparam int unsigned N_SLICE = WIDTH / MUL_SLICE;
    localparam int unsigned RAD_W   = WIDTH + FBITS;
    localparam int unsigned RB      = RAD_W / 2;
    localparam int unsigned CNT_MAX = ((N_SLICE > RB) ? N_SLICE : RB) + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    fpu_state_e             state_q;
    fpu_op_e                op_q;
    logic [WIDTH-1:0]       a_q, b_q, mag1_q, mag2_q;
    logic                   sign_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [RAD_W-1:0]       rad_q;
    logic [RB-1:0]          rem_q, root_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0]       result_q;
    logic                   busy_q, done_q, ovf_q, inv_q;

    logic [WIDTH+MUL_SLICE-1:0] pp;
    logic [2*WIDTH-1:0]     pp_wide, acc_d, prod;
    logic [WIDTH-1:0]       mag2_d, add_res, mul_res, res_d;
    logic [WIDTH:0]         a_ext, b_ext, sum;
    logic                   add_ovf, mul_ovf, ovf_d, inv_d, ge;
    logic [RB+1:0]          rem_sh, trial;
    logic [RB-1:0]          rem_d, root_d;
    logic [RAD_W-1:0]       rad_d;
    logic [CNT_W-1:0]       last_cnt;
    int unsigned            shamt;

    fpu_slice_multiplier #(
        .WIDTH    (WIDTH),
        .MUL_SLICE(MUL_SLICE)
    ) u_slice_mul (
        .a_i(mag1_q),
        .b_i(mag2_q[MUL_SLICE-1:0]),
        .p_o(pp)
    );

    // Count 0 prepares magnitudes/radicand, then one count per slice or root bit,
    // then a final count that forms the result.
    always_comb begin
        case (op_q)
            FPU_MUL:  last_cnt = CNT_W'(N_SLICE + 1);
            FPU_SQRT: last_cnt = CNT_W'(RB + 1);
            default:  last_cnt = CNT_W'(1);
        endcase

        a_ext   = {a_q[WIDTH-1], a_q};
        b_ext   = {b_q[WIDTH-1], b_q};
        sum     = (op_q == FPU_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        add_res = sum[WIDTH-1:0];

        pp_wide = '0;
        pp_wide[WIDTH+MUL_SLICE-1:0] = pp;
        shamt   = 32'(cnt_q - CNT_W'(1)) * MUL_SLICE;
        acc_d   = acc_q + (pp_wide << shamt);
        mag2_d  = mag2_q >> MUL_SLICE;

        prod    = acc_q >> FBITS;
        mul_ovf = sign_q ? (prod > {{WIDTH{1'b0}}, MIN_NEG})
                         : (prod > {{WIDTH{1'b0}}, MAX_POS});
        mul_res = sign_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];

`ifdef FPU_SATURATION_EN
        if (add_ovf) add_res = sum[WIDTH] ? MIN_NEG : MAX_POS;
        if (mul_ovf) mul_res = sign_q ? MIN_NEG : MAX_POS;
`endif

        // Restoring root step: bring down two radicand bits, try (root<<2)|1.
        rem_sh = {rem_q, rad_q[RAD_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_sh >= trial);
        rem_d  = ge ? RB'(rem_sh - trial) : rem_sh[RB-1:0];
        root_d = {root_q[RB-2:0], ge};
        rad_d  = rad_q << 2;

        case (op_q)
            FPU_MUL: begin
                res_d = mul_res;
                ovf_d = mul_ovf;
                inv_d = 1'b0;
            end
            FPU_SQRT: begin
                res_d = a_q[WIDTH-1] ? '0 : WIDTH'(root_q);
                ovf_d = 1'b0;
                inv_d = a_q[WIDTH-1];
            end
            default: begin
                res_d = add_res;
                ovf_d = add_ovf;
                inv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FPU_ST_IDLE;
            op_q     <= FPU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state_q)
                FPU_ST_IDLE: begin
                    if (start) begin
                        op_q    <= fpu_op_e'(operation);
                        a_q     <= operand_1;
                        b_q     <= operand_2;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        inv_q   <= 1'b0;
                        state_q <= FPU_ST_EXEC;
                    end
                end
                FPU_ST_EXEC: begin
                    if (cnt_q == last_cnt) begin
                        result_q <= res_d;
                        ovf_q    <= ovf_d;
                        inv_q    <= inv_d;
                        done_q   <= 1'b1;
                        state_q  <= FPU_ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == '0) begin
                            // Unsigned magnitudes keep the most-negative operand exact.
                            mag1_q <= a_q[WIDTH-1] ? -a_q : a_q;
                            mag2_q <= b_q[WIDTH-1] ? -b_q : b_q;
                            sign_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                            acc_q  <= '0;
                            rad_q  <= {a_q, {FBITS{1'b0}}};
                            rem_q  <= '0;
                            root_q <= '0;
                        end else begin
                            acc_q  <= acc_d;
                            mag2_q <= mag2_d;
                            rad_q  <= rad_d;
                            rem_q  <= rem_d;
                            root_q <= root_d;
                        end
                    end
                end
                FPU_ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= FPU_ST_IDLE;
                end
                default: state_q <= FPU_ST_IDLE;
            endcase
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign invalid  = inv_q;

endmodule

// File: tb/tb_fixed_point_seq_unit.sv
// Scoreboard bench for fixed_point_seq_unit: driver pushes model results, monitor pops on done.
// Honours FPU_SATURATION_EN for expected overflow behaviour.
module tb_fixed_point_seq_unit;
    import fixed_point_seq_unit_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned F = 10;
    localparam int unsigned S = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   operation = 2'd0;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic [W-1:0] result;
    logic         busy, done, overflow, invalid;

    int unsigned  cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb_q[$];

    fixed_point_seq_unit #(
        .WIDTH    (W),
        .FBITS    (F),
        .MUL_SLICE(S)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .operation(operation),
        .operand_1(operand_1),
        .operand_2(operand_2),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic int unsigned lat_of(input logic [1:0] op);
        case (op)
            FPU_MUL:  return W / S + 2;
            FPU_SQRT: return (W + F) / 2 + 2;
            default:  return 2;
        endcase
    endfunction

    // Reference model: plain signed 64-bit arithmetic and a real-valued square root.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, s, m1, m2, p, x, r;
        longint maxp, minn;
        bit     neg;
        maxp = 64'sd2147483647;
        minn = -64'sd2147483648;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.ovf = 1'b0; e.inv = 1'b0; e.done_cyc = 0;
        case (op)
            FPU_ADD, FPU_SUB: begin
                s = (op == FPU_SUB) ? sa - sb : sa + sb;
                e.ovf = (s > maxp) || (s < minn);
                e.res = s[31:0];
`ifdef FPU_SATURATION_EN
                if (e.ovf) e.res = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
            end
            FPU_MUL: begin
                m1  = (sa < 0) ? -sa : sa;
                m2  = (sb < 0) ? -sb : sb;
                p   = (m1 * m2) >> F;
                neg = (sa < 0) != (sb < 0);
                e.ovf = neg ? (p > maxp + 1) : (p > maxp);
                s = neg ? -p : p;
                e.res = s[31:0];
`ifdef FPU_SATURATION_EN
                if (e.ovf) e.res = neg ? 32'h80000000 : 32'h7FFFFFFF;
`endif
            end
            default: begin
                if (sa < 0) begin
                    e.inv = 1'b1;
                end else begin
                    x = sa <<< F;
                    r = longint'($sqrt(real'(x)));
                    while (r * r > x) r--;
                    while ((r + 1) * (r + 1) <= x) r++;
                    e.res = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        int unsigned guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy !== 1'b0) chk("idle_timeout", busy, 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int unsigned acc);
        exp_t e;
        wait_idle();
        start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        if (push) begin
            e = model(op, a, b);
            e.done_cyc = acc + lat_of(op);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while ((sb_q.size() != 0 || busy !== 1'b0) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb_q.size() != 0 || busy !== 1'b0) chk("drain_timeout", sb_q.size(), 0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h7FFFFFFF;
            2: v = 32'h80000000;
            3: v = $urandom_range(0, 32'h3000);
            default: v = $urandom() >> $urandom_range(0, 24);
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Monitor: pops one expectation per done pulse; otherwise result must hold.
    logic [31:0] last_res;
    logic        rst_prev = 1'b1;
    logic        done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !rst_prev) begin
            if (done) begin
                chk("done_single_pulse", done_prev, 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("overflow", overflow, e.ovf);
                    chk("invalid", invalid, e.inv);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", busy, 1);
                end
            end else begin
                chk("result_hold", result, last_res);
            end
        end
        last_res  = result;
        rst_prev  = reset;
        done_prev = done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        logic [1:0]  op;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_invalid", invalid, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(FPU_ADD,  32'h00000400, 32'h00000C00, 1, acc);
        issue(FPU_MUL,  32'h00000600, 32'hFFFFF800, 1, acc);
        issue(FPU_SQRT, 32'h00001000, 32'h0,        1, acc);
        issue(FPU_SQRT, 32'hFFFFFC00, 32'h0,        1, acc);
        issue(FPU_ADD,  32'h7FFFFFFF, 32'h00000001, 1, acc);
        issue(FPU_SUB,  32'h80000000, 32'h00000001, 1, acc);
        issue(FPU_SUB,  32'h00000000, 32'h80000000, 1, acc);
        issue(FPU_MUL,  32'h80000000, 32'h00000400, 1, acc);
        issue(FPU_MUL,  32'h80000000, 32'hFFFFFC00, 1, acc);
        issue(FPU_MUL,  32'h00100000, 32'h00100000, 1, acc);
        issue(FPU_SQRT, 32'h00000000, 32'h0,        1, acc);
        issue(FPU_SQRT, 32'h7FFFFFFF, 32'h0,        1, acc);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            issue(op, rnd_opnd(), rnd_opnd(), 1, acc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        drain();

        // start held high through a MUL: only one done, next request taken the cycle after done
        begin
            exp_t e;
            start = 1'b1; operation = FPU_MUL;
            operand_1 = 32'h00000600; operand_2 = 32'hFFFFF800;
            @(posedge clk); #1;
            acc = cyc;
            e = model(FPU_MUL, 32'h00000600, 32'hFFFFF800);
            e.done_cyc = acc + lat_of(FPU_MUL);
            sb_q.push_back(e);
            operation = FPU_ADD; operand_1 = 32'h00000400; operand_2 = 32'h00000C00;
            e = model(FPU_ADD, 32'h00000400, 32'h00000C00);
            e.done_cyc = acc + lat_of(FPU_MUL) + 2 + lat_of(FPU_ADD);
            sb_q.push_back(e);
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                chk("busy_during_spam", busy, (k != 7));
            end
            start = 1'b0;
        end
        drain();

        // reset on cycle 5 of a SQRT aborts it silently
        issue(FPU_SQRT, 32'h00001000, 32'h0, 0, acc);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("busy_before_abort", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_invalid", invalid, 0);
        reset = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        issue(FPU_ADD, 32'h00000400, 32'h00000C00, 1, acc);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
